// File: rtl/poly_sub_ctrl.sv
// Sequencer streaming two coefficient memories through the dual-lane modular subtractor into a destination memory.
// Defining POLY_SUB_CTRL_PAUSE_EN adds a `pause` input that stalls read issue while in ISSUE.

module poly_sub_ctrl #(
  parameter int WORDS    = 128,
  parameter int AW       = 7,
  parameter int DW       = 50,
  parameter int PIPE_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef POLY_SUB_CTRL_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] d_base,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [DW-1:0] rd_data_a,
  input  logic [DW-1:0] rd_data_b,
  output logic          sub_in_flag,
  output logic [DW-1:0] sub_din1,
  output logic [DW-1:0] sub_din2,
  input  logic [DW-1:0] sub_dout,
  input  logic          sub_out_flag,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       a_base_q, a_base_d;
  logic [AW-1:0]       b_base_q, b_base_d;
  logic [AW-1:0]       d_base_q, d_base_d;
  logic                err_q, err_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]       off_q [PIPE_LAT];
  logic [AW-1:0]       off_d [PIPE_LAT];
  logic                pause_w;

`ifdef POLY_SUB_CTRL_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    d_base_d = d_base_q;
    rd_en    = 1'b0;
    done     = 1'b0;
    err_d    = err_q | (sub_out_flag != vld_q[PIPE_LAT-1]);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_base_d = a_base;
          b_base_d = b_base;
          d_base_d = d_base;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!pause_w) begin
          rd_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave once only the last stage may still hold a tag; it retires on this edge.
        if (~|vld_q[PIPE_LAT-2:0]) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    vld_d    = {vld_q[PIPE_LAT-2:0], rd_en};
    off_d[0] = cnt_q;
    for (int i = 1; i < PIPE_LAT; i++) off_d[i] = off_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      d_base_q <= '0;
      err_q    <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < PIPE_LAT; i++) off_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      d_base_q <= d_base_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      off_q    <= off_d;
    end
  end

  assign rd_addr_a   = a_base_q + cnt_q;
  assign rd_addr_b   = b_base_q + cnt_q;
  assign sub_in_flag = vld_q[0];
  assign sub_din1    = rd_data_a;
  assign sub_din2    = rd_data_b;
  assign wr_en       = vld_q[PIPE_LAT-1];
  assign wr_addr     = d_base_q + off_q[PIPE_LAT-1];
  assign wr_data     = sub_dout;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Randomized bench for poly_sub_ctrl with memory/subtractor models and a whole-polynomial reference.
// Build with POLY_SUB_CTRL_PAUSE_EN defined to also exercise the pause input.

module tb_poly_sub_ctrl;
  localparam int     WORDS = 128;
  localparam int     AW    = 7;
  localparam int     DW    = 50;
  localparam longint Q     = 16515073;

  logic          clk = 1'b0;
  logic          rst, start;
`ifdef POLY_SUB_CTRL_PAUSE_EN
  logic          pause;
`endif
  logic [AW-1:0] a_base, b_base, d_base;
  logic          rd_en, sub_in_flag, sub_out_flag, wr_en, busy, done, err;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] rd_data_a = '0, rd_data_b = '0;
  logic [DW-1:0] sub_din1, sub_din2, sub_dout, wr_data;

  logic [DW-1:0] mem_a [WORDS];
  logic [DW-1:0] mem_b [WORDS];
  logic [DW-1:0] dst   [WORDS];
  logic [DW-1:0] s1 = '0, s2 = '0;
  logic          f1, f2, kill;

  int vectors = 0;
  int miscompares = 0;
  int rel, wr_count, rd_count, busy_count, done_count, done_rel, first_wr;
  int hits [WORDS];
  int pause_from, pause_len, pulse_a, pulse_b, rst_at, kill_at;

  always #5 clk = ~clk;

  poly_sub_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef POLY_SUB_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .a_base(a_base), .b_base(b_base), .d_base(d_base),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .sub_in_flag(sub_in_flag), .sub_din1(sub_din1), .sub_din2(sub_din2),
    .sub_dout(sub_dout), .sub_out_flag(sub_out_flag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [DW-1:0] modsub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] r;
    longint xa, ya;
    r = '0;
    for (int l = 0; l < 2; l++) begin
      xa = longint'(x[l*25 +: 25]);
      ya = longint'(y[l*25 +: 25]);
      r[l*25 +: 25] = 25'((xa >= ya) ? xa - ya : xa - ya + Q);
    end
    return r;
  endfunction

  // Synchronous-read source memories, destination memory and a 2-cycle subtractor.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
    if (wr_en) dst[wr_addr] <= wr_data;
    s1 <= modsub(sub_din1, sub_din2);
    s2 <= s1;
    f1 <= rst ? 1'b0 : sub_in_flag;
    f2 <= rst ? 1'b0 : f1;
  end

  assign sub_dout     = s2;
  assign sub_out_flag = f2 & ~kill;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearKnobs();
    pause_from = 0; pause_len = 0; pulse_a = -1; pulse_b = -1; rst_at = -1; kill_at = -1;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < WORDS; i++) begin
      mem_a[i] = {25'($urandom_range(0, Q - 1)), 25'($urandom_range(0, Q - 1))};
      mem_b[i] = {25'($urandom_range(0, Q - 1)), 25'($urandom_range(0, Q - 1))};
    end
  endtask

  // Launch one run and step it cycle by cycle; rel counts cycles after the start edge.
  task automatic applyStimulus(input int ab, input int bb, input int db);
    bit fin;
    wr_count = 0; rd_count = 0; busy_count = 0; done_count = 0; done_rel = -1; first_wr = -1;
    for (int i = 0; i < WORDS; i++) begin
      hits[i] = 0;
      dst[i]  = '1;
    end
    @(negedge clk);
    a_base = AW'(ab); b_base = AW'(bb); d_base = AW'(db);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rel = 1;
    fin = 1'b0;
    while (!fin && rel <= 400) begin
      start = (rel == pulse_a) || (rel == pulse_b);
      rst   = (rel == rst_at);
      kill  = (rel == kill_at);
`ifdef POLY_SUB_CTRL_PAUSE_EN
      pause = (rel >= pause_from) && (rel < pause_from + pause_len);
`endif
      @(negedge clk);
      if (rd_en) rd_count++;
      if (busy) busy_count++;
      if (done) begin
        done_count++;
        done_rel = rel;
      end
      if (wr_en) begin
        wr_count++;
        hits[wr_addr]++;
        if (first_wr < 0) first_wr = rel;
      end
      if (rel == 1) begin
        checkOutput("err_cleared_by_start", err, 0);
        checkOutput("first_rd_addr_a", rd_addr_a, ab);
        checkOutput("first_rd_addr_b", rd_addr_b, bb);
      end
      if (rel == kill_at)     checkOutput("err_before_misalign", err, 0);
      if (rel == kill_at + 1) checkOutput("err_after_misalign", err, 1);
      if (rel == rst_at + 1) begin
        checkOutput("busy_after_rst", busy, 0);
        checkOutput("wr_en_after_rst", wr_en, 0);
      end
      fin = (done_count > 0 && rel >= done_rel + 3) || (rst_at > 0 && rel >= rst_at + 12);
      @(posedge clk); #1;
      rel++;
    end
    start = 1'b0; rst = 1'b0; kill = 1'b0;
`ifdef POLY_SUB_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    if (!fin) checkOutput("run_timeout", 0, 1);
  endtask

  // Compare a completed run against the whole-polynomial reference.
  task automatic checkRun(input int ab, input int bb, input int db, input int exp_done, input int exp_err);
    int bad;
    checkOutput("wr_count", wr_count, WORDS);
    checkOutput("rd_count", rd_count, WORDS);
    checkOutput("done_count", done_count, 1);
    checkOutput("done_cycle", done_rel, exp_done);
    checkOutput("busy_cycles", busy_count, exp_done);
    checkOutput("first_write_cycle", first_wr, 4);
    checkOutput("err_end", err, exp_err);
    checkOutput("busy_idle", busy, 0);
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (hits[i] != 1) bad++;
    checkOutput("addr_not_written_once", bad, 0);
    for (int i = 0; i < WORDS; i++)
      checkOutput($sformatf("data[%0d]", (db + i) % WORDS), dst[(db + i) % WORDS],
                  modsub(mem_a[(ab + i) % WORDS], mem_b[(bb + i) % WORDS]));
  endtask

  initial begin
    int ab, bb, db;
    logic [DW-1:0] basic_exp;
    rst = 1'b1; start = 1'b0; kill = 1'b0; a_base = '0; b_base = '0; d_base = '0;
`ifdef POLY_SUB_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    clearKnobs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_sub_in_flag", sub_in_flag, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rd_addr_a", rd_addr_a, 0);
    checkOutput("rst_rd_addr_b", rd_addr_b, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] basic constant operands");
    for (int i = 0; i < WORDS; i++) begin
      mem_a[i] = {25'd5, 25'd100};
      mem_b[i] = {25'd7, 25'd40};
    end
    applyStimulus(0, 0, 0);
    checkRun(0, 0, 0, 132, 0);
    basic_exp = {25'd16515071, 25'd60};
    checkOutput("basic_word0", dst[0], basic_exp);

    $display("[TB] wrap-around bases");
    fillRandom();
    applyStimulus(120, 0, 125);
    checkRun(120, 0, 125, 132, 0);

    $display("[TB] random bases");
    for (int r = 0; r < 3; r++) begin
      fillRandom();
      ab = $urandom_range(0, WORDS - 1);
      bb = $urandom_range(0, WORDS - 1);
      db = $urandom_range(0, WORDS - 1);
      applyStimulus(ab, bb, db);
      checkRun(ab, bb, db, 132, 0);
    end

    $display("[TB] start ignored while busy");
    fillRandom();
    pulse_a = 10; pulse_b = 50;
    applyStimulus(3, 77, 40);
    checkRun(3, 77, 40, 132, 0);
    clearKnobs();

    $display("[TB] reset mid-run");
    rst_at = 60;
    applyStimulus(0, 0, 0);
    checkOutput("rst_run_writes", wr_count, 57);
    checkOutput("rst_run_done", done_count, 0);
    checkOutput("rst_run_busy", busy_count, 60);
    clearKnobs();
    fillRandom();
    applyStimulus(9, 9, 100);
    checkRun(9, 9, 100, 132, 0);

    $display("[TB] misaligned subtractor flag");
    fillRandom();
    kill_at = 40;
    applyStimulus(50, 60, 70);
    checkRun(50, 60, 70, 132, 1);
    clearKnobs();
    fillRandom();
    applyStimulus(1, 2, 3);
    checkRun(1, 2, 3, 132, 0);

`ifdef POLY_SUB_CTRL_PAUSE_EN
    $display("[TB] pause during issue");
    fillRandom();
    pause_from = 20; pause_len = 10;
    applyStimulus(5, 64, 127);
    checkRun(5, 64, 127, 142, 0);
    clearKnobs();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
